// File: rtl/aspersao_pkg.sv
// Shared types and helpers for the irrigation control blocks.
//   estado_t   : sequencer state encoding (IDLE / SPRAY / SETTLE)
//   elegivel() : irrigation condition for a single zone
package aspersao_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPRAY  = 2'd1,
    SETTLE = 2'd2
  } estado_t;

  // A zone may be watered when there is no alarm, its soil is dry, and either
  // the weather is mild with enough water in the tank, or the air is dry.
  function automatic logic elegivel(
    input logic notAlarme,
    input logic notUmidadeSolo,
    input logic notTemperatura,
    input logic nivelMedio,
    input logic notUmidadeAr
  );
    return notAlarme & notUmidadeSolo & ((notTemperatura & nivelMedio) | notUmidadeAr);
  endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per requester
//   ultimo  : index of the last requester granted
//   valid_c : at least one request is pending
//   grant_c : first requester found searching from ultimo+1 (wrapping)
module arbitro_rr #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ultimo,
  output logic                 valid_c,
  output logic [$clog2(N)-1:0] grant_c
);

  localparam int unsigned IDX_W = $clog2(N);

  int idx;

  // Scan the N positions after the last grant; the first hit wins.
  always_comb begin
    valid_c = 1'b0;
    grant_c = '0;
    idx     = 0;
    for (int k = 1; k <= int'(N); k++) begin
      idx = (int'(ultimo) + k) % int'(N);
      if (!valid_c && req[IDX_W'(idx)]) begin
        valid_c = 1'b1;
        grant_c = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/aspersao_multizona.sv
// Multi-zone sprinkler sequencer: opens at most one zone valve at a time,
// serving eligible zones round-robin with bounded run time and a settle pause.
//   clock, reset     : clock and synchronous active-high reset
//   tick             : time-base strobe; all timers advance only on it
//   mediumLevel      : tank at or above medium level
//   not_Temperatura  : temperature not high
//   not_UmidadeAr    : air humidity not high
//   not_UmidadeSolo  : per-zone soil dry
//   not_Alarme       : no alarm (0 = alarm active)
//   clearAbort       : clears alarmeAbort
//   aspersao         : valve drive, one-hot or zero
//   zonaAtiva        : zone being served (last served outside SPRAY)
//   ocupado          : high in SPRAY and SETTLE
//   alarmeAbort      : sticky flag, a run was cut short by an alarm
module aspersao_multizona
  import aspersao_pkg::*;
#(
  parameter int unsigned N_ZONES      = 4,
  parameter int unsigned MIN_ON_TICKS = 2,
  parameter int unsigned MAX_ON_TICKS = 5,
  parameter int unsigned SETTLE_TICKS = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       mediumLevel,
  input  logic                       not_Temperatura,
  input  logic                       not_UmidadeAr,
  input  logic [N_ZONES-1:0]         not_UmidadeSolo,
  input  logic                       not_Alarme,
  input  logic                       clearAbort,
  output logic [N_ZONES-1:0]         aspersao,
  output logic [$clog2(N_ZONES)-1:0] zonaAtiva,
  output logic                       ocupado,
  output logic                       alarmeAbort
);

  localparam int unsigned IDX_W = $clog2(N_ZONES);
  localparam int unsigned T_MAX = (MAX_ON_TICKS > SETTLE_TICKS) ? MAX_ON_TICKS : SETTLE_TICKS;
  localparam int unsigned TW    = $clog2(T_MAX + 1);

  estado_t              estado, estadoNext;
  logic [TW-1:0]        timer, timerNext, timerInc;
  logic [IDX_W-1:0]     ultimo, ultimoNext, zonaNext;
  logic [N_ZONES-1:0]   aspersaoNext;
  logic                 ocupadoNext, abortNext;
  logic [N_ZONES-1:0]   eleg;
  logic                 arbValid;
  logic [IDX_W-1:0]     arbGrant;

  // Per-zone eligibility.
  always_comb begin
    eleg = '0;
    for (int i = 0; i < int'(N_ZONES); i++) begin
      eleg[i] = elegivel(not_Alarme, not_UmidadeSolo[i], not_Temperatura,
                         mediumLevel, not_UmidadeAr);
    end
  end

  arbitro_rr #(
    .N (N_ZONES)
  ) uArbitro (
    .req     (eleg),
    .ultimo  (ultimo),
    .valid_c (arbValid),
    .grant_c (arbGrant)
  );

  assign timerInc = timer + TW'(1);

  // Next-state and next-output logic.
  always_comb begin
    estadoNext = estado;
    timerNext  = timer;
    zonaNext   = zonaAtiva;
    ultimoNext = ultimo;
    abortNext  = alarmeAbort & ~clearAbort;

    case (estado)
      IDLE: begin
        if (arbValid) begin
          zonaNext   = arbGrant;
          ultimoNext = arbGrant;
          timerNext  = '0;
          estadoNext = SPRAY;
        end
      end

      SPRAY: begin
        if (!not_Alarme) begin
          // Alarm closes the valve immediately, regardless of tick.
          estadoNext = SETTLE;
          abortNext  = 1'b1;
          timerNext  = '0;
        end else if (tick && (timerInc == TW'(MAX_ON_TICKS))) begin
          estadoNext = SETTLE;
          timerNext  = '0;
        end else if (!eleg[zonaAtiva] && (timer >= TW'(MIN_ON_TICKS))) begin
          // Early stop once the minimum run has been satisfied.
          estadoNext = SETTLE;
          timerNext  = '0;
        end else if (tick) begin
          timerNext = timerInc;
        end
      end

      SETTLE: begin
        if (SETTLE_TICKS == 0) begin
          estadoNext = IDLE;
          timerNext  = '0;
        end else if (tick) begin
          if (timerInc == TW'(SETTLE_TICKS)) begin
            estadoNext = IDLE;
            timerNext  = '0;
          end else begin
            timerNext = timerInc;
          end
        end
      end

      default: begin
        estadoNext = IDLE;
        timerNext  = '0;
      end
    endcase

    // Outputs are registered from the next state so they track the FSM edge.
    aspersaoNext = (estadoNext == SPRAY) ? (N_ZONES'(1) << zonaNext) : '0;
    ocupadoNext  = (estadoNext != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= IDLE;
      timer       <= '0;
      zonaAtiva   <= '0;
      ultimo      <= IDX_W'(N_ZONES - 1);
      aspersao    <= '0;
      ocupado     <= 1'b0;
      alarmeAbort <= 1'b0;
    end else begin
      estado      <= estadoNext;
      timer       <= timerNext;
      zonaAtiva   <= zonaNext;
      ultimo      <= ultimoNext;
      aspersao    <= aspersaoNext;
      ocupado     <= ocupadoNext;
      alarmeAbort <= abortNext;
    end
  end

endmodule
